// File: rtl/sparse_index_sequencer_if.sv
// sparse_index_sequencer_if
// Handshake and data bundle between an upstream block source, the sparse
// index sequencer and the downstream mux/multiplier.
//   in_valid/in_ready   : block handshake (source -> sequencer)
//   in_act_data         : BLOCK_NUMBER activations, element i at [DW*(i+1)-1 : DW*i]
//   in_bitmap           : bit i set means weight i is nonzero
//   in_weight_data      : packed nonzero weights, slot k = k-th set bitmap bit
//   out_valid/out_ready : beat handshake (sequencer -> downstream)
//   out_act_data        : held activation block
//   out_mask            : index of the current set bit
//   out_weight          : weight for out_mask
//   out_last            : last beat of the block
//   out_skip            : one-cycle pulse after an all-zero block is accepted
// modport master: the block source / beat consumer side.
// modport slave : the sequencer side.
interface sparse_index_sequencer_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int BLOCK_NUMBER = 16
);
  logic                               in_valid;
  logic                               in_ready;
  logic [BLOCK_NUMBER*DATA_WIDTH-1:0] in_act_data;
  logic [BLOCK_NUMBER-1:0]            in_bitmap;
  logic [BLOCK_NUMBER*DATA_WIDTH-1:0] in_weight_data;
  logic                               out_valid;
  logic                               out_ready;
  logic [BLOCK_NUMBER*DATA_WIDTH-1:0] out_act_data;
  logic [3:0]                         out_mask;
  logic [DATA_WIDTH-1:0]              out_weight;
  logic                               out_last;
  logic                               out_skip;

  modport master (
    output in_valid, in_act_data, in_bitmap, in_weight_data, out_ready,
    input  in_ready, out_valid, out_act_data, out_mask, out_weight,
           out_last, out_skip
  );

  modport slave (
    input  in_valid, in_act_data, in_bitmap, in_weight_data, out_ready,
    output in_ready, out_valid, out_act_data, out_mask, out_weight,
           out_last, out_skip
  );
endinterface

// File: rtl/sparse_index_sequencer.sv
// sparse_index_sequencer
// Accepts one block of activations with a nonzero-weight bitmap and packed
// nonzero weights, then emits one beat per set bitmap bit (lowest index
// first) carrying the select index, the matching weight and the held block.
// All-zero blocks are swallowed and flagged with a one-cycle out_skip pulse.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : sparse_index_sequencer_if slave modport (block in, beats out)
module sparse_index_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int BLOCK_NUMBER = 16
) (
  input logic                     clk,
  input logic                     rst_n,
  sparse_index_sequencer_if.slave bus
);

  localparam int BUS_WIDTH = BLOCK_NUMBER * DATA_WIDTH;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                  state_q;
  logic [BLOCK_NUMBER-1:0] bitmap_q;
  logic [4:0]              k_q;
  logic [BUS_WIDTH-1:0]    act_q;
  logic [BUS_WIDTH-1:0]    weight_q;
  logic                    skip_q;

  logic [3:0]              lowest_idx;
  logic [DATA_WIDTH-1:0]   slot_weight;
  logic                    one_left;
  logic                    running;
  logic                    accept;
  logic                    beat_done;

  // Priority encoder over the remaining bitmap; scanning downwards lets the
  // lowest set bit win.
  always_comb begin
    lowest_idx = '0;
    for (int i = BLOCK_NUMBER - 1; i >= 0; i--) begin
      if (bitmap_q[i]) begin
        lowest_idx = 4'(i);
      end
    end
  end

  // k only reaches 16 after the final beat has been consumed, where no slot
  // exists; return zero there rather than wrapping to slot 0.
  assign slot_weight = k_q[4] ? '0 : weight_q[k_q[3:0]*DATA_WIDTH +: DATA_WIDTH];

  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign one_left = (bitmap_q != '0) &&
                    ((bitmap_q & (bitmap_q - BLOCK_NUMBER'(1))) == '0);

  assign running   = (state_q == RUN);
  assign accept    = bus.in_valid & bus.in_ready;
  assign beat_done = running & bus.out_ready;

  // Outputs come only from registers; in_ready alone looks at out_ready so a
  // new block can load on the final beat without a bubble.
  assign bus.out_valid    = running;
  assign bus.out_mask     = running ? lowest_idx : '0;
  assign bus.out_weight   = running ? slot_weight : '0;
  assign bus.out_last     = running & one_left;
  assign bus.out_act_data = act_q;
  assign bus.out_skip     = skip_q;
  assign bus.in_ready     = ~running | (bus.out_ready & one_left);

  // Block load has priority: in RUN it can only happen together with the
  // last handshake, so the finishing block needs no further update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitmap_q <= '0;
      k_q      <= '0;
      act_q    <= '0;
      weight_q <= '0;
      skip_q   <= 1'b0;
    end else begin
      skip_q <= accept && (bus.in_bitmap == '0);
      if (accept) begin
        act_q    <= bus.in_act_data;
        bitmap_q <= bus.in_bitmap;
        weight_q <= bus.in_weight_data;
        k_q      <= '0;
        state_q  <= (bus.in_bitmap != '0) ? RUN : IDLE;
      end else if (beat_done) begin
        bitmap_q <= bitmap_q & (bitmap_q - BLOCK_NUMBER'(1));
        k_q      <= k_q + 5'd1;
        if (one_left) begin
          state_q <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_sparse_index_sequencer.sv
// tb_sparse_index_sequencer
// Self-checking bench for sparse_index_sequencer: a table of directed blocks,
// hand-written multi-cycle sequences (back-pressure, back-to-back, reset
// mid-block) and randomized traffic against a beat-list reference model.
module tb_sparse_index_sequencer;

  localparam int DW = 8;
  localparam int BN = 16;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;

  sparse_index_sequencer_if #(.DATA_WIDTH(DW), .BLOCK_NUMBER(BN)) bus ();

  sparse_index_sequencer #(.DATA_WIDTH(DW), .BLOCK_NUMBER(BN)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]  bitmap;
    logic [127:0] weights;
    logic [127:0] act;
    int           n_beats;
    logic [63:0]  exp_masks;
    logic [127:0] exp_weights;
  } vec_t;

  typedef struct {
    logic [3:0]   mask;
    logic [7:0]   weight;
    logic         last;
    logic [127:0] act;
  } beat_t;

  vec_t  vecs [6];
  beat_t exp_q [$];

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] bm,
                               input logic [127:0] w, input logic [127:0] act,
                               input logic ready);
    bus.in_valid       = valid;
    bus.in_bitmap      = bm;
    bus.in_weight_data = w;
    bus.in_act_data    = act;
    bus.out_ready      = ready;
  endtask

  // One table block with out_ready held high, every beat compared.
  task automatic runDirected(input int v);
    @(negedge clk);
    applyStimulus(1'b1, vecs[v].bitmap, vecs[v].weights, vecs[v].act, 1'b1);
    #1;
    checkOutput("dir_in_ready_idle", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    if (vecs[v].n_beats == 0) begin
      checkOutput("dir_skip_pulse", bus.out_skip, 1);
      checkOutput("dir_skip_no_valid", bus.out_valid, 0);
      checkOutput("dir_skip_in_ready", bus.in_ready, 1);
      @(negedge clk);
      #1;
      checkOutput("dir_skip_one_cycle", bus.out_skip, 0);
      checkOutput("dir_skip_still_idle", bus.out_valid, 0);
    end else begin
      for (int j = 0; j < vecs[v].n_beats; j++) begin
        checkOutput("dir_valid", bus.out_valid, 1);
        checkOutput("dir_mask", bus.out_mask, vecs[v].exp_masks[4*j +: 4]);
        checkOutput("dir_weight", bus.out_weight, vecs[v].exp_weights[8*j +: 8]);
        checkOutput("dir_last", bus.out_last, (j == vecs[v].n_beats - 1));
        checkOutput("dir_act_held", bus.out_act_data, vecs[v].act);
        if (j == vecs[v].n_beats - 1) checkOutput("dir_in_ready_last", bus.in_ready, 1);
        @(negedge clk);
        #1;
      end
      checkOutput("dir_back_to_idle", bus.out_valid, 0);
    end
  endtask

  logic [15:0]  rnd_bm;
  logic [127:0] rnd_w;
  logic [127:0] rnd_act;

  task automatic newBlock();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0)      rnd_bm = 16'h0000;
    else if (sel == 1) rnd_bm = 16'hFFFF;
    else               rnd_bm = 16'($urandom & $urandom);
    rnd_w   = {$urandom, $urandom, $urandom, $urandom};
    rnd_act = {$urandom, $urandom, $urandom, $urandom};
  endtask

  // Reference model: the beat list of a block, straight from the rules
  // (walk set bits low to high, hand out weight slots in order).
  task automatic pushBeats(input logic [15:0] bm, input logic [127:0] w,
                           input logic [127:0] act);
    int n;
    int total;
    beat_t b;
    n = 0;
    total = $countones(bm);
    for (int i = 0; i < 16; i++) begin
      if (bm[i]) begin
        b.mask   = 4'(i);
        b.weight = w[8*n +: 8];
        b.last   = (n == total - 1);
        b.act    = act;
        exp_q.push_back(b);
        n++;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   pending;
    logic rdy;
    logic exp_ready;
    logic exp_skip;
    logic acc;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{16'h8421, 128'hDEADBEEF_CAFEF00D_01234567_44332211,
                128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0, 4,
                64'hFA50, 128'h44332211};
    vecs[1] = '{16'h0000, 128'h11111111_22222222_33333333_44444444,
                128'h55555555_66666666_77777777_88888888, 0, 64'h0, 128'h0};
    vecs[2] = '{16'hFFFF, 128'h100F0E0D_0C0B0A09_08070605_04030201,
                128'hA1A2A3A4_B1B2B3B4_C1C2C3C4_D1D2D3D4, 16,
                64'hFEDCBA98_76543210, 128'h100F0E0D_0C0B0A09_08070605_04030201};
    vecs[3] = '{16'h0006, 128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A500C3B7,
                128'h00000000_00000000_00000000_12345678, 2, 64'h21, 128'hC3B7};
    vecs[4] = '{16'h0001, 128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFF5A,
                128'h99999999_88888888_77777777_66666666, 1, 64'h0, 128'h5A};
    vecs[5] = '{16'h8000, 128'h00000000_00000000_00000000_000000E7,
                128'h13579BDF_2468ACE0_FEDCBA98_76543210, 1, 64'hF, 128'hE7};

    rst_n = 1'b0;
    applyStimulus(1'b0, 16'h0, 128'h0, 128'h0, 1'b0);
    #3;
    checkOutput("rst_out_valid", bus.out_valid, 0);
    checkOutput("rst_out_mask", bus.out_mask, 0);
    checkOutput("rst_out_weight", bus.out_weight, 0);
    checkOutput("rst_out_last", bus.out_last, 0);
    checkOutput("rst_out_skip", bus.out_skip, 0);
    checkOutput("rst_out_act", bus.out_act_data, 0);
    checkOutput("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 6; v++) runDirected(v);

    // Back-pressure: 0x0006 with out_ready low for three cycles.
    @(negedge clk);
    applyStimulus(1'b1, 16'h0006, 128'h0000BB0A, 128'h77, 1'b1);
    @(posedge clk);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = (c == 3);
      #1;
      checkOutput("bp_valid_held", bus.out_valid, 1);
      checkOutput("bp_mask_held", bus.out_mask, 1);
      checkOutput("bp_weight_held", bus.out_weight, 8'h0A);
      checkOutput("bp_last_low", bus.out_last, 0);
    end
    @(negedge clk);
    #1;
    checkOutput("bp_second_mask", bus.out_mask, 2);
    checkOutput("bp_second_weight", bus.out_weight, 8'hBB);
    checkOutput("bp_second_last", bus.out_last, 1);
    @(negedge clk);
    #1;
    checkOutput("bp_done", bus.out_valid, 0);

    // Back-to-back: A=0x0003 then B=0x0100 with in_valid held high.
    @(negedge clk);
    applyStimulus(1'b1, 16'h0003, 128'h0201, 128'hAAAA, 1'b1);
    @(posedge clk);
    @(negedge clk);
    applyStimulus(1'b1, 16'h0100, 128'h33, 128'hBBBB, 1'b1);
    #1;
    checkOutput("b2b_a0_mask", bus.out_mask, 0);
    checkOutput("b2b_a0_not_ready", bus.in_ready, 0);
    @(negedge clk);
    #1;
    checkOutput("b2b_a1_mask", bus.out_mask, 1);
    checkOutput("b2b_a1_last", bus.out_last, 1);
    checkOutput("b2b_a1_ready", bus.in_ready, 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checkOutput("b2b_b_valid", bus.out_valid, 1);
    checkOutput("b2b_b_mask", bus.out_mask, 8);
    checkOutput("b2b_b_weight", bus.out_weight, 8'h33);
    checkOutput("b2b_b_act", bus.out_act_data, 128'hBBBB);
    checkOutput("b2b_b_last", bus.out_last, 1);
    @(negedge clk);
    #1;
    checkOutput("b2b_idle", bus.out_valid, 0);

    // Reset in the middle of a 0x00F0 block.
    @(negedge clk);
    applyStimulus(1'b1, 16'h00F0, 128'h44332211, 128'hCC, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    checkOutput("rmid_beat1", bus.out_mask, 4);
    @(negedge clk);
    #1;
    checkOutput("rmid_beat2", bus.out_mask, 5);
    @(posedge clk);
    #1;
    checkOutput("rmid_pre_valid", bus.out_valid, 1);
    checkOutput("rmid_pre_mask", bus.out_mask, 6);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rmid_async_valid", bus.out_valid, 0);
    checkOutput("rmid_async_mask", bus.out_mask, 0);
    checkOutput("rmid_async_last", bus.out_last, 0);
    checkOutput("rmid_async_in_ready", bus.in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    runDirected(4);

    // Randomized traffic against the beat-list model.
    exp_q.delete();
    exp_skip = 1'b0;
    pending  = 200;
    newBlock();
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (pending == 0 && exp_q.size() == 0 && !exp_skip) break;
      @(negedge clk);
      rdy = ($urandom_range(0, 99) < 70);
      applyStimulus((pending > 0) && ($urandom_range(0, 99) < 60),
                    rnd_bm, rnd_w, rnd_act, rdy);
      #1;
      exp_ready = (exp_q.size() == 0) || (rdy && exp_q[0].last);
      checkOutput("rnd_in_ready", bus.in_ready, exp_ready);
      checkOutput("rnd_out_valid", bus.out_valid, exp_q.size() != 0);
      checkOutput("rnd_out_skip", bus.out_skip, exp_skip);
      if (exp_q.size() != 0) begin
        checkOutput("rnd_mask", bus.out_mask, exp_q[0].mask);
        checkOutput("rnd_weight", bus.out_weight, exp_q[0].weight);
        checkOutput("rnd_last", bus.out_last, exp_q[0].last);
        checkOutput("rnd_act", bus.out_act_data, exp_q[0].act);
        if (rdy) void'(exp_q.pop_front());
      end
      acc = bus.in_valid && exp_ready;
      exp_skip = acc && (rnd_bm == 16'h0);
      if (acc) begin
        pushBeats(rnd_bm, rnd_w, rnd_act);
        pending--;
        newBlock();
      end
    end
    checkOutput("rnd_drained", (pending == 0) && (exp_q.size() == 0), 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sparse_index_sequencer.md
Name: sparse_index_sequencer

Overview:
- Upstream feeder of the activation pre-process mux. Accepts one block of BLOCK_NUMBER activations, a BLOCK_NUMBER-bit nonzero-weight bitmap and the packed nonzero weights.
- Emits one beat per set bitmap bit, lowest index first. Each beat carries the 4-bit select index (drives the mux mask), the matching weight and the held activation block.
- Zero-weight positions are skipped, so the downstream multiplier only sees useful pairs.

Parameters:
- DATA_WIDTH, 8, bits per activation and per weight.
- BLOCK_NUMBER, 16, elements per block. Fixed at 16 because the select index is 4 bits.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream block valid.
- in_ready  output  1  sequencer can accept a block.
- in_act_data  input  BLOCK_NUMBER*DATA_WIDTH  activation block; element i is at [DATA_WIDTH*(i+1)-1 : DATA_WIDTH*i].
- in_bitmap  input  BLOCK_NUMBER  bit i=1 means weight i is nonzero.
- in_weight_data  input  BLOCK_NUMBER*DATA_WIDTH  packed nonzero weights; slot k holds the weight for the k-th set bitmap bit, counted from bit 0. Unused slots are don't-care.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream accepts beat.
- out_act_data  output  BLOCK_NUMBER*DATA_WIDTH  registered copy of the accepted block; held constant for all beats of that block.
- out_mask  output  4  index of the current set bit.
- out_weight  output  DATA_WIDTH  weight for out_mask.
- out_last  output  1  current beat is the last beat of the block.
- out_skip  output  1  one-cycle pulse: an all-zero bitmap block was accepted.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE.
  - remaining-bitmap, slot counter k, act and weight registers = 0.
  - out_valid=0, out_mask=0, out_weight=0, out_last=0, out_skip=0.
  - in_ready=1 once in IDLE.
- Clocking and outputs:
  - All outputs are decoded from registers only; there is no combinational path from the in_* inputs to the out_* outputs.
  - in_ready is the exception: it depends on out_ready.
- States:
  - IDLE: out_valid=0; in_ready=1.
  - RUN: out_valid=1. in_ready = out_ready & out_last, so a new block can load on the final beat without a bubble.
- Accept: in_valid & in_ready at a rising edge latches act, bitmap and weights, and sets k=0.
  - bitmap != 0: next state RUN.
  - bitmap == 0: stay in IDLE (or go to IDLE from RUN), assert out_skip for exactly the next cycle, produce no beats.
- Beat decode in RUN:
  - out_mask = index of the lowest set bit of the remaining bitmap.
  - out_weight = weight slot k.
  - out_last = 1 when the remaining bitmap has exactly one set bit.
- Handshake (out_valid & out_ready):
  - Clear the lowest set bit; k <= k+1.
  - If out_last and no accept in the same cycle, next state IDLE.
  - If out_last and a simultaneous accept of a nonzero block, stay in RUN with the new block; its first beat is presented the next cycle.
- Back-pressure: while out_ready=0, out_mask, out_weight, out_last and out_act_data hold stable and out_valid stays 1.
- Latency: block accepted at edge N gives its first beat valid in cycle N+1. A block with P set bits needs P handshakes.
- Throughput: one beat per cycle when out_ready is held high.
- Counter width: k is 5 bits (0..16). The maximum of 16 beats occurs for bitmap 0xFFFF, with k reaching 15 on the last beat.
- Abort: reset asserted mid-block discards the block. Outputs return to their reset values immediately (asynchronously).

Test Plan:
- Basic sparse block:
  - Stimulus: bitmap=0x8421, weights slots 0..3 = 0x11,0x22,0x33,0x44, out_ready=1.
  - Response: beats (mask,weight) = (0,0x11),(5,0x22),(10,0x33),(15,0x44) on consecutive cycles; out_last only on the 4th beat; in_ready=1 on the 4th beat; IDLE afterwards.
- Back-pressure:
  - Stimulus: bitmap=0x0006; out_ready low for 3 cycles after out_valid rises.
  - Response: mask=1 held stable for 4 cycles, then mask=2 with out_last=1; no beat lost or duplicated.
- All-zero block:
  - Stimulus: bitmap=0x0000 accepted.
  - Response: out_skip=1 for exactly one cycle; out_valid stays 0; in_ready stays 1.
- Dense block:
  - Stimulus: bitmap=0xFFFF, weight slot i = i+1.
  - Response: 16 beats with mask 0..15 and weight 1..16; out_last only on mask=15; out_act_data constant throughout.
- Back-to-back blocks:
  - Stimulus: block A bitmap=0x0003, then block B bitmap=0x0100 presented with in_valid=1 throughout.
  - Response: B accepted on A's last handshake; beats mask 0, 1, 8 in three consecutive cycles with no idle bubble.
- Reset mid-operation:
  - Stimulus: bitmap=0x00F0; assert rst_n=0 after the 2nd beat.
  - Response: out_valid, out_mask and out_last drop to 0 without waiting for a clock edge; after release, in_ready=1 and a fresh block with bitmap=0x0001 yields a single beat with mask=0 and out_last=1.
